// File: rtl/aligned_stream_buffer.sv
// rtl/aligned_stream_buffer.sv - per-channel FIFOs with a lock-step aligned output register
module aligned_stream_buffer #(
  parameter int CHANNELS     = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 16,
  parameter int AF_THRESH    = BUFFER_DEPTH - 2,
  localparam int LW          = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 flush_i,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  wr_channels_i,
  input  logic [CHANNELS-1:0]                  wr_valids_i,
  input  logic                                 wr_sof_i,
  input  logic                                 wr_eof_i,
  output logic [CHANNELS-1:0]                  wr_readys_o,
  output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  rd_channels_o,
  output logic                                 rd_valid_o,
  input  logic                                 rd_ready_i,
  output logic                                 rd_sof_o,
  output logic                                 rd_eof_o,
  output logic [CHANNELS-1:0][LW-1:0]          levels_o,
  output logic [CHANNELS-1:0]                  almost_full_o,
  output logic [CHANNELS-1:0]                  overflow_o
);

  localparam int            PW       = $clog2(BUFFER_DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(BUFFER_DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);

  logic [CHANNELS-1:0]                 nonempty;
  logic [CHANNELS-1:0]                 push;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] head;
  logic [1:0]                          head_tag;
  logic                                load;

  // A beat only leaves when every channel can contribute a word.
  assign load = (&nonempty) && (!rd_valid_o || rd_ready_i);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LW-1:0]         level;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

    assign push[c]          = wr_valids_i[c] && (level != FULL_LVL);
    assign nonempty[c]      = (level != '0);
    assign head[c]          = mem[rd_ptr];
    assign levels_o[c]      = level;
    assign wr_readys_o[c]   = (level != FULL_LVL);
    assign almost_full_o[c] = (level >= AF_LVL);
    assign overflow_o[c]    = ovf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else if (flush_i) begin
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + PW'(1);
        if (load)    rd_ptr <= rd_ptr + PW'(1);
        if (wr_valids_i[c] && !push[c]) ovf <= 1'b1;
        case ({push[c], load})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[c] && !flush_i) mem[wr_ptr] <= wr_channels_i[c];
    end

    // Frame tags ride alongside channel 0 so they stay aligned with its words.
    if (c == 0) begin : g_tag
      logic [1:0] tag_mem [BUFFER_DEPTH];

      always_ff @(posedge clk_i) begin
        if (push[0] && !flush_i) tag_mem[wr_ptr] <= {wr_sof_i, wr_eof_i};
      end

      assign head_tag = tag_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o    <= 1'b0;
      rd_channels_o <= '0;
      rd_sof_o      <= 1'b0;
      rd_eof_o      <= 1'b0;
    end else if (flush_i) begin
      rd_valid_o    <= 1'b0;
      rd_channels_o <= '0;
      rd_sof_o      <= 1'b0;
      rd_eof_o      <= 1'b0;
    end else if (load) begin
      rd_valid_o             <= 1'b1;
      rd_channels_o          <= head;
      {rd_sof_o, rd_eof_o}   <= head_tag;
    end else if (rd_ready_i) begin
      rd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aligned_stream_buffer.sv
// tb/tb_aligned_stream_buffer.sv - randomized queue-model bench for aligned_stream_buffer
module tb_aligned_stream_buffer;
  localparam int CH = 2;
  localparam int DW = 16;
  localparam int D  = 16;
  localparam int LW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [CH-1:0][DW-1:0]  wr_data;
  logic [CH-1:0]          wr_valids;
  logic                   sof, eof, rdy;
  logic [CH-1:0]          wr_readys;
  logic [CH-1:0][DW-1:0]  rd_data;
  logic                   rd_valid, rd_sof, rd_eof;
  logic [CH-1:0][LW-1:0]  levels;
  logic [CH-1:0]          af, ovf;

  aligned_stream_buffer #(.CHANNELS(CH), .DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .wr_channels_i(wr_data), .wr_valids_i(wr_valids), .wr_sof_i(sof), .wr_eof_i(eof),
    .wr_readys_o(wr_readys), .rd_channels_o(rd_data), .rd_valid_o(rd_valid),
    .rd_ready_i(rdy), .rd_sof_o(rd_sof), .rd_eof_o(rd_eof),
    .levels_o(levels), .almost_full_o(af), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: plain queues plus the visible output beat.
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  logic [1:0]    mt[$];
  logic          m_valid;
  logic [DW-1:0] m_out0, m_out1;
  logic [1:0]    m_tags;
  logic [1:0]    m_ovf;
  logic          last_hs;
  logic [DW-1:0] last_hd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete(); mt.delete();
    m_valid = 1'b0; m_out0 = '0; m_out1 = '0; m_tags = 2'b00; m_ovf = 2'b00;
  endtask

  task automatic model_edge();
    bit acc0, acc1, ld;
    if (flush) begin
      model_reset();
    end else begin
      acc0 = wr_valids[0] && (mq0.size() < D);
      acc1 = wr_valids[1] && (mq1.size() < D);
      if (wr_valids[0] && !acc0) m_ovf[0] = 1'b1;
      if (wr_valids[1] && !acc1) m_ovf[1] = 1'b1;
      ld = (mq0.size() > 0) && (mq1.size() > 0) && (!m_valid || rdy);
      if (ld) begin
        m_out0  = mq0.pop_front();
        m_out1  = mq1.pop_front();
        m_tags  = mt.pop_front();
        m_valid = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (acc0) begin
        mq0.push_back(wr_data[0]);
        mt.push_back({sof, eof});
      end
      if (acc1) mq1.push_back(wr_data[1]);
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, m_valid);
    check("rd_data", rd_data, {m_out1, m_out0});
    check("rd_tags", {rd_sof, rd_eof}, m_tags);
    check("levels", levels, {5'(mq1.size()), 5'(mq0.size())});
    check("wr_readys", wr_readys, {mq1.size() != D, mq0.size() != D});
    check("almost_full", af, {mq1.size() >= D - 2, mq0.size() >= D - 2});
    check("overflow", ovf, m_ovf);
  endtask

  task automatic step(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic s, input logic e, input logic r, input logic f);
    @(negedge clk);
    wr_valids = v; wr_data[0] = d0; wr_data[1] = d1;
    sof = s; eof = e; rdy = r; flush = f;
    last_hs = rd_valid && r;
    last_hd = rd_data[0];
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rd_valid, 1'b0);
    check({tag, "_data"}, rd_data, '0);
    check({tag, "_tags"}, {rd_sof, rd_eof}, 2'b00);
    check({tag, "_levels"}, levels, '0);
    check({tag, "_ovf_af"}, {ovf, af}, 4'b0000);
    check({tag, "_readys"}, wr_readys, 2'b11);
  endtask

  initial begin
    int beats;
    int exp_idx;
    logic r;
    rst_n = 1'b1; flush = 1'b0; wr_valids = '0; wr_data = '0;
    sof = 1'b0; eof = 1'b0; rdy = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Alignment latency: ch0 written at edge 1, ch1 at edge 3, beat after edge 4.
    step(2'b01, 16'h11, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("align_no_partial", rd_valid, 1'b0);
    step(2'b10, 16'h0, 16'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    check("align_edge3", rd_valid, 1'b0);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("align_edge4", rd_valid, 1'b1);
    check("align_data", rd_data, {16'h22, 16'h11});
    check("align_sof", rd_sof, 1'b1);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("align_drain", rd_valid, 1'b0);

    // Fill channel 0 past full.
    for (int i = 0; i < 17; i++) begin
      step(2'b01, DW'(i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 12) check("af_below", af[0], 1'b0);
      if (i == 13) check("af_at_14", af[0], 1'b1);
      if (i == 15) check("ovf_at_full", ovf[0], 1'b0);
    end
    check("ovf_set", ovf[0], 1'b1);
    check("full_ready", wr_readys[0], 1'b0);
    check("full_level", levels[0], 5'd16);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_flush", ovf, 2'b00);

    // Flush with levels {5,3} and a valid beat held.
    for (int i = 0; i < 4; i++) step(2'b11, DW'(i), DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(2'b01, DW'(i), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_flush_levels", levels, {5'd3, 5'd5});
    check("pre_flush_valid", rd_valid, 1'b1);
    step(2'b11, 16'h5, 16'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_levels", levels, '0);
    check("flush_valid", rd_valid, 1'b0);

    // Ordered delivery under a 1,0,0,1 ready pattern.
    for (int i = 0; i < 8; i++) step(2'b11, DW'(i), DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    exp_idx = 0;
    for (int i = 0; i < 32; i++) begin
      r = (i % 4 == 0) || (i % 4 == 3);
      step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, r, 1'b0);
      if (last_hs) begin
        check("order", last_hd, DW'(exp_idx));
        exp_idx++;
      end
    end
    check("order_count", exp_idx, 8);

    // Sustained throughput from empty.
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    beats = 0;
    for (int i = 0; i < 100; i++) begin
      step(2'b11, DW'(i), DW'(i + 100), 1'b0, 1'b0, 1'b1, 1'b0);
      if (rd_valid) beats++;
    end
    check("throughput", beats, 99);
    check("steady_levels", levels, {5'd1, 5'd1});

    // Randomized traffic with rare flushes and a mid-stream async reset.
    for (int i = 0; i < 2000; i++) begin
      step({$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6},
           DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), $urandom_range(0, 199) == 0);
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        wr_valids = '0;
        flush = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/aligned_stream_buffer.md
ALIGNED_STREAM_BUFFER -- requirements
Module: aligned_stream_buffer

Interface
REQ-001 Parameter: CHANNELS, 2, number of parallel data channels (>=1).
REQ-002 Parameter: DATA_WIDTH, 16, bits per channel word (>=1).
REQ-003 Parameter: BUFFER_DEPTH, 16, entries per channel FIFO; power of two, >=2.
REQ-004 Parameter: AF_THRESH, BUFFER_DEPTH-2, level at or above which almost_full_o[c] asserts.
REQ-005 Derived: LW = $clog2(BUFFER_DEPTH)+1, level width.
REQ-006 clk_i  in  1  single clock; all logic on posedge.
REQ-007 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-008 flush_i  in  1  synchronous clear of all FIFOs, output stage, sticky flags.
REQ-009 wr_channels_i  in  DATA_WIDTH x [CHANNELS]  per-channel write data.
REQ-010 wr_valids_i  in  1 x [CHANNELS]  per-channel write strobe.
REQ-011 wr_sof_i  in  1  start-of-frame tag, sampled with channel 0 write.
REQ-012 wr_eof_i  in  1  end-of-frame tag, sampled with channel 0 write.
REQ-013 wr_readys_o  out  1 x [CHANNELS]  channel c not full.
REQ-014 rd_channels_o  out  DATA_WIDTH x [CHANNELS]  aligned output words.
REQ-015 rd_valid_o  out  1  output beat valid.
REQ-016 rd_ready_i  in  1  downstream accepts beat.
REQ-017 rd_sof_o / rd_eof_o  out  1 each  tags travelling with channel 0 word.
REQ-018 levels_o  out  LW x [CHANNELS]  per-channel FIFO occupancy (excludes output register).
REQ-019 almost_full_o  out  1 x [CHANNELS]  levels_o[c] >= AF_THRESH.
REQ-020 overflow_o  out  1 x [CHANNELS]  sticky: write dropped on channel c.

Function
REQ-021 Each channel shall have an independent BUFFER_DEPTH-entry FIFO; channel 0 stores {sof, eof, data}.
REQ-022 Write on channel c accepted at edge iff wr_valids_i[c] && levels_o[c] < BUFFER_DEPTH (pre-edge value), regardless of simultaneous pop.
REQ-023 Write while full shall be dropped, FIFO unchanged, overflow_o[c] set at that edge and held until flush or reset.
REQ-024 wr_readys_o[c] = (levels_o[c] != BUFFER_DEPTH), combinational from registered level.
REQ-025 Output is one register stage; load condition: all channels level>0 AND (!rd_valid_o || rd_ready_i).
REQ-026 On load, one word shall pop from every channel simultaneously and rd_valid_o shall be 1 next cycle.
REQ-027 If rd_valid_o && rd_ready_i and load condition false, rd_valid_o shall drop to 0 next cycle.
REQ-028 While rd_valid_o && !rd_ready_i, rd_channels_o, rd_sof_o, rd_eof_o shall hold stable.
REQ-029 Latency: word written at edge k (last channel to become non-empty) appears with rd_valid_o=1 after edge k+1; no combinational fall-through.
REQ-030 Sustained throughput 1 beat/cycle when all channels non-empty and rd_ready_i=1.
REQ-031 Level update per edge: +1 on accepted write, -1 on pop, unchanged when both; pointers wrap modulo BUFFER_DEPTH.
REQ-032 Pop and write on same channel same edge while level==1 shall be legal; level stays 1.
REQ-033 flush_i=1 shall, at that edge, zero all levels and pointers, clear rd_valid_o and overflow_o; writes and pops that edge ignored.
REQ-034 Channels with data while others empty shall not emit; no partial beats ever.

Reset
REQ-035 rst_n_i=0 shall immediately force: levels_o=0, rd_valid_o=0, rd_sof_o=0, rd_eof_o=0, rd_channels_o=0, overflow_o=0, almost_full_o=0, wr_readys_o=1.
REQ-036 Reset mid-transfer discards all stored data; first post-reset beat shall be first post-reset write.
REQ-037 FIFO storage array need not be reset.

Verification
REQ-038 CHANNELS=2: write ch0=0x11 (sof=1) edge 1, ch1=0x22 edge 3, rd_ready_i=1 -> rd_valid_o=1 after edge 4 only, rd_channels_o={0x11,0x22}, rd_sof_o=1.
REQ-039 Fill ch0 with 16 words (DEPTH=16), 17th write -> dropped, overflow_o[0]=1, wr_readys_o[0]=0, levels_o[0]=16, almost_full_o[0]=1 from level 14.
REQ-040 Both channels loaded with 0..7, rd_ready_i toggled 1,0,0,1... -> outputs 0..7 in order, data stable while stalled, no duplicates or losses.
REQ-041 Continuous writes and rd_ready_i=1 for 100 cycles -> 1 beat/cycle after 2-cycle warm-up, levels constant.
REQ-042 flush_i=1 with levels {5,3} and rd_valid_o=1 -> next cycle levels {0,0}, rd_valid_o=0, overflow_o=0.
REQ-043 rst_n_i pulsed low between edges mid-stream -> outputs zero immediately without waiting for clock edge.
